square_pll: RTL and testbench
=============================

Name: square_pll

Overview:
- Carrier-regeneration stage of the square-law recovery chain. Sits directly downstream of the 2fc bandpass filter and consumes its 15-bit signed output.
- Tracks the 2fc tone with a second-order digital PLL: sign-reference phase detector, PI loop filter and 32-bit NCO.
- Divides the NCO by two to produce in-phase and quadrature fc square-wave carriers (inherent 180° ambiguity).
- Provides a windowed lock indicator.

Parameters:
- FREQ_INIT, 32'h4000_0000, NCO free-run increment; the NCO runs at 2fc.
- KP_SHIFT, 4, proportional gain = 2^KP_SHIFT.
- KI_SHIFT, 8, integrator output scaling = 2^-KI_SHIFT.
- LOCK_WIN_LOG2, 8, lock window = 2^LOCK_WIN_LOG2 samples.
- LOCK_THRESH, 32'd500000, lock threshold on the window accumulator.

Ports:
- clk  in  1  system clock; one sample per cycle.
- rst  in  1  synchronous reset, active-high.
- din  in  15 signed, bandpass filter output (2fc tone).
- carrier_i  out  1  recovered fc carrier, in-phase.
- carrier_q  out  1  recovered fc carrier, quadrature (lags carrier_i by 90°).
- nco_phase  out  32  NCO phase accumulator ph.
- loop_ctrl  out  32  signed loop-filter output ctrl.
- locked  out  1  lock indicator.

Behaviour:
- Reset: synchronous; every register clears to 0 on the clock edge where rst=1. This covers din_r, pd, integ, ctrl, ph, carrier_i, carrier_q, window counter, both accumulators and locked. Reset mid-operation discards all loop state; the loop restarts free-running at FREQ_INIT on the first cycle after rst deasserts.
- Pipeline: a sample presented at edge n follows this path:
  - edge n: din_r <= din.
  - edge n+1: pd valid.
  - edge n+2: integ and ctrl valid.
  - edge n+3: ph <= ph + FREQ_INIT + ctrl, mod 2^32 wrap allowed.
  - Loop latency is 3 cycles.
- Phase detector:
  - pd = ph[31] ? -din_r : din_r (din_r multiplied by the sign of the NCO sine).
  - -(-16384) saturates to +16383.
  - pd is 15-bit signed, registered.
- Loop filter:
  - integ_next = integ + sext(pd), saturating at ±(2^31-1).
  - integ <= integ_next.
  - ctrl <= sat32((sext(pd) <<< KP_SHIFT) + (integ_next >>> KI_SHIFT)), using arithmetic shift.
- Divider:
  - carrier_i toggles on the edge where ph[31] goes 0→1.
  - carrier_q toggles on the edge where ph[31] goes 1→0.
  - Both are registered; they update 1 cycle after the ph transition. Comparison uses the previous-cycle ph[31].
- Lock detector:
  - ip = (ph[31]^ph[30]) ? -din_r : din_r, same saturation rule as pd.
  - acc += sext(ip) every cycle; win_cnt increments.
  - When win_cnt wraps to 0, locked is evaluated on acc, then acc clears:
    - acc > LOCK_THRESH: locked <= 1.
    - acc < LOCK_THRESH>>1: locked <= 0.
    - otherwise locked holds (hysteresis).
- Boundaries:
  - ph wrap 0xFFFF_FFFF→0 is a normal 1→0 transition of ph[31] and toggles carrier_q.
  - An increment ≥2^31 is legal but aliases; no special handling.
  - Integrator stays pinned while saturated and recovers linearly.
  - din=0 gives pd=0, ctrl=integ>>>KI_SHIFT, and a constant frequency.

Test Plan:
- Reset mid-run: rst=1 for 3 cycles during tracking → all outputs 0 from the first rst edge. After release, ph sequence is 0, FREQ_INIT, 2·FREQ_INIT, ...
- Free-run: din=0, FREQ_INIT=2^30 → ph cycles 0, 2^30, 2^31, 3·2^30.
  - carrier_i period 8 clks.
  - carrier_q toggles exactly 2 clks after each carrier_i toggle.
  - loop_ctrl=0, locked stays 0.
- Filter arithmetic: from reset, din=+1000 constant with ph[31]=0 at the pd edge → first pd=1000, integ=1000, loop_ctrl=16003 (16000+3). Next ph increment equals 2^30+16003.
- Saturation: din=-16384 while ph[31]=1 → pd=+16383, not -16384.
- Acquisition: din=round(8000·cos(2π·n/8)), FREQ_INIT=2^29+2^22 →
  - locked=1 within 4000 cycles.
  - Steady state: carrier_i period 16 clks, mean loop_ctrl ≈ -2^22.
- Lock loss: after lock, din forced to 0 → locked=0 within 2 windows (512 cycles), and the NCO holds its last frequency.

Source files
------------

// File: rtl/square_pll_if.sv
// square_pll_if: sample input and recovered-carrier outputs of the square-law carrier PLL.
`default_nettype none

interface square_pll_if;
  logic signed [14:0] din;
  logic               carrier_i;
  logic               carrier_q;
  logic        [31:0] nco_phase;
  logic signed [31:0] loop_ctrl;
  logic               locked;

  modport master (
    output din,
    input  carrier_i, carrier_q, nco_phase, loop_ctrl, locked
  );

  modport slave (
    input  din,
    output carrier_i, carrier_q, nco_phase, loop_ctrl, locked
  );
endinterface

`default_nettype wire

// File: rtl/square_pll.sv
// square_pll: second-order sign-reference PLL locking a 32-bit NCO to the 2fc tone,
// halved into I/Q fc square carriers, with a windowed lock detector. Rev 1.0.
`default_nettype none

module square_pll #(
  parameter logic [31:0] FREQ_INIT     = 32'h4000_0000,
  parameter int          KP_SHIFT      = 4,
  parameter int          KI_SHIFT      = 8,
  parameter int          LOCK_WIN_LOG2 = 8,
  parameter logic [31:0] LOCK_THRESH   = 32'd500000
) (
  input  logic         clk,
  input  logic         rst,
  square_pll_if.slave  bus
);

  localparam logic signed [14:0] S15_MIN   = 15'sh4000;
  localparam logic signed [14:0] S15_MAX   = 15'sh3FFF;
  localparam logic signed [32:0] INTEG_MAX = 33'sd2147483647;
  localparam logic signed [32:0] INTEG_MIN = -33'sd2147483647;
  localparam logic signed [33:0] CTRL_MAX  = 34'sd2147483647;
  localparam logic signed [33:0] CTRL_MIN  = -34'sd2147483648;
  localparam logic signed [31:0] THRESH_HI = $signed(LOCK_THRESH);
  localparam logic signed [31:0] THRESH_LO = $signed(LOCK_THRESH >> 1);

  // Negation that keeps -(-16384) inside the 15-bit range.
  function automatic logic signed [14:0] neg_sat(input logic signed [14:0] x);
    return (x == S15_MIN) ? S15_MAX : -x;
  endfunction

  logic signed [14:0]          din_r;
  logic signed [14:0]          pd;
  logic signed [31:0]          integ;
  logic signed [31:0]          ctrl;
  logic        [31:0]          ph;
  logic                        ph_msb_d;
  logic                        car_i;
  logic                        car_q;
  logic signed [31:0]          acc;
  logic [LOCK_WIN_LOG2-1:0]    win_cnt;
  logic                        lock_flag;

  logic signed [14:0]          pd_next;
  logic signed [14:0]          ip;
  logic signed [32:0]          integ_sum;
  logic signed [31:0]          integ_next;
  logic signed [33:0]          pd_ext;
  logic signed [33:0]          integ_ext;
  logic signed [33:0]          ctrl_sum;
  logic signed [31:0]          ctrl_next;
  logic signed [31:0]          acc_sum;
  logic        [31:0]          ph_next;
  logic                        win_wrap;

  always_comb begin
    pd_next = ph[31] ? neg_sat(din_r) : din_r;
    // Quadrature reference: sign of the NCO cosine.
    ip      = (ph[31] ^ ph[30]) ? neg_sat(din_r) : din_r;

    integ_sum = 33'(pd) + 33'(integ);
    if (integ_sum > INTEG_MAX) begin
      integ_next = INTEG_MAX[31:0];
    end else if (integ_sum < INTEG_MIN) begin
      integ_next = INTEG_MIN[31:0];
    end else begin
      integ_next = integ_sum[31:0];
    end

    pd_ext    = 34'(pd);
    integ_ext = 34'(integ_next);
    ctrl_sum  = (pd_ext <<< KP_SHIFT) + (integ_ext >>> KI_SHIFT);
    if (ctrl_sum > CTRL_MAX) begin
      ctrl_next = CTRL_MAX[31:0];
    end else if (ctrl_sum < CTRL_MIN) begin
      ctrl_next = CTRL_MIN[31:0];
    end else begin
      ctrl_next = ctrl_sum[31:0];
    end

    ph_next  = ph + FREQ_INIT + $unsigned(ctrl);
    acc_sum  = acc + 32'(ip);
    win_wrap = &win_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_r     <= '0;
      pd        <= '0;
      integ     <= '0;
      ctrl      <= '0;
      ph        <= '0;
      ph_msb_d  <= 1'b0;
      car_i     <= 1'b0;
      car_q     <= 1'b0;
      acc       <= '0;
      win_cnt   <= '0;
      lock_flag <= 1'b0;
    end else begin
      din_r    <= bus.din;
      pd       <= pd_next;
      integ    <= integ_next;
      ctrl     <= ctrl_next;
      ph       <= ph_next;
      ph_msb_d <= ph[31];
      // Divide-by-two: I on the rising MSB edge, Q on the falling one.
      if (!ph_msb_d && ph[31]) car_i <= ~car_i;
      if (ph_msb_d && !ph[31]) car_q <= ~car_q;
      win_cnt <= win_cnt + LOCK_WIN_LOG2'(1);
      if (win_wrap) begin
        acc <= '0;
        if (acc_sum > THRESH_HI) begin
          lock_flag <= 1'b1;
        end else if (acc_sum < THRESH_LO) begin
          lock_flag <= 1'b0;
        end
      end else begin
        acc <= acc_sum;
      end
    end
  end

  assign bus.carrier_i = car_i;
  assign bus.carrier_q = car_q;
  assign bus.nco_phase = ph;
  assign bus.loop_ctrl = ctrl;
  assign bus.locked    = lock_flag;

endmodule

`default_nettype wire

// File: tb/tb_square_pll.sv
// tb_square_pll: randomized and directed checks of square_pll against a behavioural loop model.
`default_nettype none

module tb_square_pll;
  localparam logic [31:0] FREQ = 32'h4000_0000;
  localparam longint      IMAX = 64'sd2147483647;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  square_pll_if bus();
  square_pll dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  longint      m_din_r, m_pd, m_integ, m_ctrl, m_acc;
  logic [31:0] m_ph;
  bit          m_ci, m_cq, m_msb, m_locked;
  int          m_cnt;

  function automatic longint flip(input longint x);
    return (x == -16384) ? 64'sd16383 : -x;
  endfunction

  function automatic longint clamp(input longint x, input longint lo, input longint hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  // One clock edge of the loop as described by its sample-path rules.
  task automatic model_edge(input bit r, input longint d);
    longint pd_n, integ_n, ctrl_n, ipv;
    logic [31:0] ph_n;
    if (r) begin
      m_din_r = 0; m_pd = 0; m_integ = 0; m_ctrl = 0; m_acc = 0; m_ph = '0;
      m_ci = 0; m_cq = 0; m_msb = 0; m_locked = 0; m_cnt = 0;
      return;
    end
    pd_n    = m_ph[31] ? flip(m_din_r) : m_din_r;
    integ_n = clamp(m_integ + m_pd, -IMAX, IMAX);
    ctrl_n  = clamp(m_pd * 16 + (integ_n >>> 8), -IMAX - 1, IMAX);
    ph_n    = m_ph + FREQ + 32'(m_ctrl);
    if (!m_msb && m_ph[31]) m_ci = !m_ci;
    if (m_msb && !m_ph[31]) m_cq = !m_cq;
    m_msb = m_ph[31];
    ipv   = (m_ph[31] ^ m_ph[30]) ? flip(m_din_r) : m_din_r;
    m_acc += ipv;
    m_cnt++;
    if (m_cnt == 256) begin
      if (m_acc > 500000) m_locked = 1;
      else if (m_acc < 250000) m_locked = 0;
      m_acc = 0;
      m_cnt = 0;
    end
    m_din_r = d; m_pd = pd_n; m_integ = integ_n; m_ctrl = ctrl_n; m_ph = ph_n;
  endtask

  function automatic logic [66:0] mdl_vec();
    return {m_ph, 32'(m_ctrl), m_ci, m_cq, m_locked};
  endfunction

  function automatic logic [66:0] dut_vec();
    return {bus.nco_phase, bus.loop_ctrl, bus.carrier_i, bus.carrier_q, bus.locked};
  endfunction

  task automatic step(input longint d);
    bus.din = 15'(d);
    @(posedge clk);
    model_edge(rst, d);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(longint'($signed(15'($urandom))));
      checks++;
      if (dut_vec() !== 67'd0) begin
        errors++;
        $display("FAIL reset: outputs %h expected 0", dut_vec());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset(1);
    for (int k = 1; k <= 16; k++) begin
      step(0);
      checks++;
      if (bus.nco_phase !== 32'(k * 64'h4000_0000) || bus.loop_ctrl !== 32'sd0 || bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL free_run k=%0d: ph=%h ctrl=%0d lk=%b expected ph=%h ctrl=0 lk=0",
                 k, bus.nco_phase, bus.loop_ctrl, bus.locked, 32'(k * 64'h4000_0000));
      end
      checks++;
      if (bus.carrier_i !== 1'(((k + 1) / 4) % 2) || bus.carrier_q !== 1'(((k - 1) / 4) % 2)) begin
        errors++;
        $display("FAIL free_run_carrier k=%0d: i=%b q=%b expected i=%b q=%b", k,
                 bus.carrier_i, bus.carrier_q, 1'(((k + 1) / 4) % 2), 1'(((k - 1) / 4) % 2));
      end
    end
  endtask

  task automatic test_filter_arith();
    logic [31:0] ph3;
    do_reset(1);
    step(1000);
    step(1000);
    step(1000);
    checks++;
    if (bus.loop_ctrl !== 32'sd16003) begin
      errors++;
      $display("FAIL filter_ctrl: got %0d expected 16003", bus.loop_ctrl);
    end
    ph3 = bus.nco_phase;
    step(1000);
    checks++;
    if (bus.nco_phase - ph3 !== 32'h4000_0000 + 32'd16003) begin
      errors++;
      $display("FAIL filter_incr: got %h expected %h", bus.nco_phase - ph3, 32'h4000_0000 + 32'd16003);
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int i = 1; i <= 24; i++) begin
      step(-16384);
      if (i == 4) begin
        checks++;
        if (bus.loop_ctrl !== 32'sd262127) begin
          errors++;
          $display("FAIL sat_pd: ctrl=%0d expected 262127", bus.loop_ctrl);
        end
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL sat_model i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    longint d;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       d = -16384;
        1:       d = 16383;
        default: d = longint'($signed(15'($urandom)));
      endcase
      step(d);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(longint'($signed(15'($urandom))));
      checks++;
      if (dut_vec() !== 67'd0) begin
        errors++;
        $display("FAIL reset_mid i=%0d: outputs %h expected 0", i, dut_vec());
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(0);
      checks++;
      if (bus.nco_phase !== 32'(k * 64'h4000_0000)) begin
        errors++;
        $display("FAIL reset_mid_ph k=%0d: got %h expected %h", k, bus.nco_phase, 32'(k * 64'h4000_0000));
      end
    end
  endtask

  task automatic test_lock_and_loss();
    logic [31:0] pn, prev, delta0;
    do_reset(1);
    // Drive a tone aligned with the in-phase reference the NCO will present next cycle.
    for (int i = 0; i < 600; i++) begin
      pn = m_ph + FREQ + 32'(m_ctrl);
      step((pn[31] ^ pn[30]) ? -12000 : 12000);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL lock_model i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_acquire: locked=%b expected 1", bus.locked);
    end
    delta0 = '0;
    for (int i = 0; i < 512; i++) begin
      prev = bus.nco_phase;
      step(0);
      if (i == 10) delta0 = bus.nco_phase - prev;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL loss_model i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_loss: locked=%b expected 0", bus.locked);
    end
    prev = bus.nco_phase;
    step(0);
    checks++;
    if (bus.nco_phase - prev !== delta0 || delta0 !== FREQ + $unsigned(bus.loop_ctrl)) begin
      errors++;
      $display("FAIL hold_freq: incr=%h expected %h (ctrl=%0d)", bus.nco_phase - prev, delta0, bus.loop_ctrl);
    end
  endtask

  initial begin
    bus.din = '0;
    test_reset();
    test_free_run();
    test_filter_arith();
    test_saturation();
    test_random();
    test_reset_mid();
    test_lock_and_loss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
